// File: rtl/pi_loop_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pi_loop_scheduler_if : sample, reference, shared-stage and output bus |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pi_loop_scheduler_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 4,
   parameter int CH_BITS    = 2
);
   logic [CHANNELS-1:0]            s_valid;
   logic [CHANNELS*DATA_WIDTH-1:0] s_data;
   logic                           ref_wr;
   logic [CH_BITS-1:0]             ref_addr;
   logic [DATA_WIDTH-1:0]          ref_data;
   logic [DATA_WIDTH-1:0]          dp_reference;
   logic [DATA_WIDTH-1:0]          dp_data_in;
   logic [DATA_WIDTH-1:0]          dp_error;
   logic                           m_valid;
   logic                           m_ready;
   logic [DATA_WIDTH-1:0]          m_error;
   logic [CH_BITS-1:0]             m_channel;
   logic [CHANNELS-1:0]            overrun;
   logic                           busy;

   // Environment side: samples, references, shared stage result, downstream ready.
   modport master (
      output s_valid, s_data, ref_wr, ref_addr, ref_data, dp_error, m_ready,
      input  dp_reference, dp_data_in, m_valid, m_error, m_channel, overrun, busy
   );

   modport slave (
      input  s_valid, s_data, ref_wr, ref_addr, ref_data, dp_error, m_ready,
      output dp_reference, dp_data_in, m_valid, m_error, m_channel, overrun, busy
   );
endinterface
`default_nettype wire

// File: rtl/pi_loop_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pi_loop_scheduler : round-robin sharing of one error stage           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pi_loop_scheduler #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 4,
   parameter int CH_BITS    = 2,
   parameter int DP_LATENCY = 1
) (
   input  wire logic         clk,
   input  wire logic         reset,
   pi_loop_scheduler_if.slave bus
);
   localparam int c_CNT_BITS = (DP_LATENCY < 2) ? 1 : $clog2(DP_LATENCY + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_grant_en;
   logic                  w_capture;
   logic                  w_handshake;
   logic [CH_BITS-1:0]    w_grant;
   int                    w_idx;

   logic [CHANNELS-1:0]   r_pending;
   logic [CHANNELS-1:0]   r_overrun;
   logic [DATA_WIDTH-1:0] r_sample [CHANNELS];
   logic [DATA_WIDTH-1:0] r_ref    [CHANNELS];
   logic [CH_BITS-1:0]    r_last_grant;
   logic [c_CNT_BITS-1:0] r_cnt;
   logic [DATA_WIDTH-1:0] r_dp_reference;
   logic [DATA_WIDTH-1:0] r_dp_data_in;
   logic [DATA_WIDTH-1:0] r_m_error;
   logic [CH_BITS-1:0]    r_m_channel;
   logic                  r_m_valid;

   // Scan from the highest offset down so the nearest pending channel after last_grant wins.
   always_comb begin
      w_grant = '0;
      w_idx   = 0;
      for (int k = CHANNELS; k >= 1; k--) begin
         w_idx = (int'(r_last_grant) + k) % CHANNELS;
         if (r_pending[w_idx]) w_grant = CH_BITS'(w_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_en  = 1'b0;
      w_capture   = 1'b0;
      w_handshake = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|r_pending) begin
               w_grant_en  = 1'b1;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            if (r_m_valid && bus.m_ready) begin
               w_handshake = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A sample arriving on its own grant edge re-arms pending without counting as an overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
         r_overrun <= '0;
         for (int i = 0; i < CHANNELS; i++) r_sample[i] <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (bus.s_valid[i]) begin
               r_sample[i]  <= bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
               r_pending[i] <= 1'b1;
               if (r_pending[i] && !(w_grant_en && int'(w_grant) == i))
                  r_overrun[i] <= 1'b1;
            end else if (w_grant_en && int'(w_grant) == i) begin
               r_pending[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) r_ref[i] <= '0;
      end else if (bus.ref_wr && int'(bus.ref_addr) < CHANNELS) begin
         r_ref[bus.ref_addr] <= bus.ref_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_dp_reference <= '0;
         r_dp_data_in   <= '0;
         r_m_error      <= '0;
         r_m_channel    <= '0;
         r_m_valid      <= 1'b0;
         r_last_grant   <= CH_BITS'(CHANNELS - 1);
         r_cnt          <= '0;
      end else begin
         if (w_grant_en) begin
            r_dp_reference <= r_ref[w_grant];
            r_dp_data_in   <= r_sample[w_grant];
            r_m_channel    <= w_grant;
            r_last_grant   <= w_grant;
            r_cnt          <= c_CNT_BITS'(DP_LATENCY);
         end else if (r_state == ST_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_BITS'(1);
         end
         if (w_capture) begin
            r_m_error <= bus.dp_error;
            r_m_valid <= 1'b1;
         end else if (w_handshake) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign bus.dp_reference = r_dp_reference;
   assign bus.dp_data_in   = r_dp_data_in;
   assign bus.m_valid      = r_m_valid;
   assign bus.m_error      = r_m_error;
   assign bus.m_channel    = r_m_channel;
   assign bus.overrun      = r_overrun;
   assign bus.busy         = (r_state != ST_IDLE);
endmodule
`default_nettype wire
